// File: rtl/scan_mux_n_to_1_pkg.sv
// Shared definitions for the scanning N:1 registered multiplexer:
// mode enum, default parameter values and a clog2 width helper.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_SCAN_DIV = 4;

  // Bits needed to index 'value' items, never less than 1.
  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_mux_n_to_1_div_counter.sv
// Dwell divider for scan mode: counts 0..SCAN_DIV-1 while inc_en is high
// and pulses tc on the cycle whose edge completes a dwell period.
module scan_mux_div_counter
  import scan_mux_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc_en,
  output logic tc
);

  localparam int DIVW = clog2_min1(SCAN_DIV);
  localparam logic [DIVW-1:0] CNT_LAST = DIVW'(SCAN_DIV - 1);
  localparam logic [DIVW-1:0] CNT_ZERO = {DIVW{1'b0}};
  localparam logic [DIVW-1:0] CNT_ONE  = DIVW'(1);

  logic [DIVW-1:0] count_r;

  // Dwell counter: clear has priority, wraps to zero at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (clr) begin
      count_r <= CNT_ZERO;
    end else if (inc_en) begin
      if (count_r == CNT_LAST) begin
        count_r <= CNT_ZERO;
      end else begin
        count_r <= count_r + CNT_ONE;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // A clear on the same edge suppresses the advance.
  assign tc = inc_en & ~clr & (count_r == CNT_LAST);

endmodule

// File: rtl/scan_mux_n_to_1.sv
// Registered N-channel, WIDTH-bit multiplexer with enable, manual select
// and an auto-scan mode that rotates through every channel, SCAN_DIV
// cycles per channel.
// Build option: SCAN_MUX_HOLD_ON_DISABLE_EN -- when defined, a disabled
// block keeps its last out/out_valid instead of clearing them.
module scan_mux_n_to_1
  import scan_mux_pkg::*;
#(
  parameter  int N_CH     = DEF_N_CH,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int SCAN_DIV = DEF_SCAN_DIV,
  localparam int SELW     = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]       sel,
  input  logic                  en,
  input  logic                  scan,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic [SELW-1:0]       cur_ch
);

  // Channel table padded to a power of two so any sel value indexes safely.
  localparam int NSLOT = 1 << SELW;
  localparam logic [SELW-1:0]  CH_LAST  = SELW'(N_CH - 1);
  localparam logic [SELW-1:0]  CH_ZERO  = {SELW{1'b0}};
  localparam logic [SELW-1:0]  CH_ONE   = SELW'(1);
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] ch_s [NSLOT];

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_next_s;
  logic             out_valid_r;
  logic             out_valid_next_s;
  logic [SELW-1:0]  cur_ch_r;
  logic [SELW-1:0]  cur_ch_next_s;
  logic             sel_ok_s;
  logic             div_clr_s;
  logic             div_inc_s;
  logic             div_tc_s;

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < N_CH) begin : g_live
      assign ch_s[k] = in_bus[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign ch_s[k] = DATA_ZERO;
    end
  end

  assign sel_ok_s = (int'(sel) < N_CH);

  // Mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Mode for the coming edge follows en/scan directly; disable wins.
  always_comb begin
    state_next_s = ST_IDLE;
    if (!en) begin
      state_next_s = ST_IDLE;
    end else if (scan) begin
      state_next_s = ST_SCAN;
    end else begin
      state_next_s = ST_MANUAL;
    end
  end

  // The divider only runs in scan; it is zeroed on the edge that leaves
  // scan, so it already sits at 0 whenever scan is (re)entered.
  assign div_inc_s = (state_next_s == ST_SCAN);
  assign div_clr_s = (state_r == ST_SCAN) && (state_next_s != ST_SCAN);

  scan_mux_div_counter #(
    .SCAN_DIV (SCAN_DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (div_clr_s),
    .inc_en (div_inc_s),
    .tc     (div_tc_s)
  );

  // Next output/channel values for the mode being entered at this edge.
  always_comb begin
    out_next_s       = out_r;
    out_valid_next_s = out_valid_r;
    cur_ch_next_s    = cur_ch_r;
    case (state_next_s)
      ST_MANUAL: begin
        if (sel_ok_s) begin
          out_next_s       = ch_s[sel];
          out_valid_next_s = 1'b1;
          cur_ch_next_s    = sel;
        end else begin
          out_next_s       = DATA_ZERO;
          out_valid_next_s = 1'b0;
          cur_ch_next_s    = cur_ch_r;
        end
      end
      ST_SCAN: begin
        // Data comes from the pre-edge channel, so out trails cur_ch by one.
        out_next_s       = ch_s[cur_ch_r];
        out_valid_next_s = 1'b1;
        if (div_tc_s) begin
          if (cur_ch_r == CH_LAST) begin
            cur_ch_next_s = CH_ZERO;
          end else begin
            cur_ch_next_s = cur_ch_r + CH_ONE;
          end
        end else begin
          cur_ch_next_s = cur_ch_r;
        end
      end
      ST_IDLE: begin
`ifdef SCAN_MUX_HOLD_ON_DISABLE_EN
        out_next_s       = out_r;
        out_valid_next_s = out_valid_r;
`else
        out_next_s       = DATA_ZERO;
        out_valid_next_s = 1'b0;
`endif
        cur_ch_next_s    = cur_ch_r;
      end
      default: begin
        out_next_s       = DATA_ZERO;
        out_valid_next_s = 1'b0;
        cur_ch_next_s    = cur_ch_r;
      end
    endcase
  end

  // Output register: the only path to the observation port, glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= DATA_ZERO;
      out_valid_r <= 1'b0;
      cur_ch_r    <= CH_ZERO;
    end else begin
      out_r       <= out_next_s;
      out_valid_r <= out_valid_next_s;
      cur_ch_r    <= cur_ch_next_s;
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign cur_ch    = cur_ch_r;

endmodule

// File: tb/tb_scan_mux_n_to_1.sv
// Directed, table-driven bench for scan_mux_n_to_1 (4 ch / 8 bit / dwell 3)
// plus a 3-channel, dwell-1 instance for out-of-range select and mod-3 wrap.
module tb_scan_mux_n_to_1;

`ifdef SCAN_MUX_HOLD_ON_DISABLE_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] in_bus;
  logic [1:0]  sel;
  logic        en;
  logic        scan;
  logic [7:0]  out;
  logic        out_valid;
  logic [1:0]  cur_ch;

  logic [23:0] in_bus3;
  logic [1:0]  sel3;
  logic        en3;
  logic        scan3;
  logic [7:0]  out3;
  logic        out_valid3;
  logic [1:0]  cur_ch3;

  int n_checks = 0;
  int n_fail   = 0;

  scan_mux_n_to_1 #(.N_CH(4), .WIDTH(8), .SCAN_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .en(en),
    .scan(scan), .out(out), .out_valid(out_valid), .cur_ch(cur_ch)
  );

  scan_mux_n_to_1 #(.N_CH(3), .WIDTH(8), .SCAN_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus3), .sel(sel3), .en(en3),
    .scan(scan3), .out(out3), .out_valid(out_valid3), .cur_ch(cur_ch3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        scan;
    logic [1:0]  sel;
    logic [31:0] bus;
    logic [7:0]  exp_out;
    logic        exp_valid;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic e, input logic s, input logic [1:0] sl,
                     input logic [31:0] b, input logic [7:0] eo,
                     input logic ev, input logic [1:0] ec);
    vec_t v;
    v.en = e; v.scan = s; v.sel = sl; v.bus = b;
    v.exp_out = eo; v.exp_valid = ev; v.exp_ch = ec;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_main(input string nm, input logic [7:0] eo,
                            input logic ev, input logic [1:0] ec);
    check({nm, ".out"},       {24'h0, out},       {24'h0, eo});
    check({nm, ".out_valid"}, {31'h0, out_valid}, {31'h0, ev});
    check({nm, ".cur_ch"},    {30'h0, cur_ch},    {30'h0, ec});
  endtask

  task automatic check_n3(input string nm, input logic [7:0] eo,
                          input logic ev, input logic [1:0] ec);
    check({nm, ".out"},       {24'h0, out3},       {24'h0, eo});
    check({nm, ".out_valid"}, {31'h0, out_valid3}, {31'h0, ev});
    check({nm, ".cur_ch"},    {30'h0, cur_ch3},    {30'h0, ec});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    logic [7:0]  idle_a;
    logic [7:0]  idle_b;
    logic [7:0]  exp_seq [4];
    logic [1:0]  ch_seq [4];

    d  = 32'h4433_2211;
    d2 = 32'hA55A_FF00;
    idle_a = HOLD ? 8'h11 : 8'h00;
    idle_b = HOLD ? 8'h22 : 8'h00;

    // Manual select, data follows sel with one cycle of latency.
    add(1'b1, 1'b0, 2'd2, d, 8'h33, 1'b1, 2'd2);
    add(1'b1, 1'b0, 2'd0, d, 8'h11, 1'b1, 2'd0);
    add(1'b1, 1'b0, 2'd3, d, 8'h44, 1'b1, 2'd3);
    add(1'b1, 1'b0, 2'd0, d, 8'h11, 1'b1, 2'd0);
    // Scan from channel 0, dwell 3, sel ignored, wrap back to 0x11.
    add(1'b1, 1'b1, 2'd3, d, 8'h11, 1'b1, 2'd0);
    add(1'b1, 1'b1, 2'd3, d, 8'h11, 1'b1, 2'd0);
    add(1'b1, 1'b1, 2'd3, d, 8'h11, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd3, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd3, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd3, d, 8'h22, 1'b1, 2'd2);
    add(1'b1, 1'b1, 2'd3, d, 8'h33, 1'b1, 2'd2);
    add(1'b1, 1'b1, 2'd3, d, 8'h33, 1'b1, 2'd2);
    add(1'b1, 1'b1, 2'd3, d, 8'h33, 1'b1, 2'd3);
    add(1'b1, 1'b1, 2'd3, d, 8'h44, 1'b1, 2'd3);
    add(1'b1, 1'b1, 2'd3, d, 8'h44, 1'b1, 2'd3);
    add(1'b1, 1'b1, 2'd3, d, 8'h44, 1'b1, 2'd0);
    add(1'b1, 1'b1, 2'd3, d, 8'h11, 1'b1, 2'd0);
    // Disable during scan: cleared (or held) output, channel frozen.
    add(1'b0, 1'b1, 2'd3, d, idle_a, HOLD, 2'd0);
    add(1'b0, 1'b0, 2'd0, d, idle_a, HOLD, 2'd0);
    // Manual sel=1 then scan; en drops on the terminal-count cycle.
    add(1'b1, 1'b0, 2'd1, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd0, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd0, d, 8'h22, 1'b1, 2'd1);
    add(1'b0, 1'b1, 2'd0, d, idle_b, HOLD, 2'd1);
    // Re-entry restarts the full dwell on channel 1.
    add(1'b1, 1'b1, 2'd0, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd0, d, 8'h22, 1'b1, 2'd1);
    add(1'b1, 1'b1, 2'd0, d, 8'h22, 1'b1, 2'd2);
    add(1'b1, 1'b1, 2'd0, d, 8'h33, 1'b1, 2'd2);
    // Different data pattern in manual mode.
    add(1'b1, 1'b0, 2'd3, d2, 8'hA5, 1'b1, 2'd3);
    add(1'b1, 1'b0, 2'd1, d2, 8'hFF, 1'b1, 2'd1);

    rst_n = 1'b0; in_bus = d; sel = 2'd0; en = 1'b0; scan = 1'b0;
    in_bus3 = 24'hCC_BB_AA; sel3 = 2'd0; en3 = 1'b0; scan3 = 1'b0;
    #7;
    check_main("reset", 8'h00, 1'b0, 2'd0);
    check_n3("reset3", 8'h00, 1'b0, 2'd0);
    #1 rst_n = 1'b1;
    tick();
    check_main("idle_after_reset", 8'h00, 1'b0, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; scan = vq[i].scan; sel = vq[i].sel; in_bus = vq[i].bus;
      tick();
      check_main($sformatf("vec%0d", i), vq[i].exp_out, vq[i].exp_valid, vq[i].exp_ch);
    end

    // Asynchronous reset in the middle of a scan, then scan restarts at 0.
    in_bus = d; en = 1'b1; scan = 1'b1; sel = 2'd3;
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check_main("async_reset", 8'h00, 1'b0, 2'd0);
    #1 rst_n = 1'b1;
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h11; exp_seq[2] = 8'h11; exp_seq[3] = 8'h22;
    ch_seq[0]  = 2'd0;  ch_seq[1]  = 2'd0;  ch_seq[2]  = 2'd1;  ch_seq[3]  = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_main($sformatf("post_reset_scan%0d", i), exp_seq[i], 1'b1, ch_seq[i]);
    end

    // Three-channel instance: out-of-range select and modulo-3 wrap, dwell 1.
    en3 = 1'b1; scan3 = 1'b0; sel3 = 2'd1;
    tick();
    check_n3("n3_sel1", 8'hBB, 1'b1, 2'd1);
    sel3 = 2'd3;
    tick();
    check_n3("n3_sel3_oor", 8'h00, 1'b0, 2'd1);
    scan3 = 1'b1;
    tick();
    check_n3("n3_scan0", 8'hBB, 1'b1, 2'd2);
    tick();
    check_n3("n3_scan1_wrap", 8'hCC, 1'b1, 2'd0);
    tick();
    check_n3("n3_scan2", 8'hAA, 1'b1, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_mux_n_to_1.md
Name: scan_mux_n_to_1

Overview:
Parametrised, registered N-channel, W-bit multiplexer with enable. It generalises the team's enable 2:1 mux:
- Output is registered: 1-cycle latency, glitch-free.
- Manual-select mode: `sel` picks the channel.
- Auto-scan mode: an internal divider rotates through all channels, SCAN_DIV cycles each.
- Used for debug/status channel selection in front of observation ports.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 8, bits per channel (>=1).
- SCAN_DIV, 4, cycles each channel is presented in scan mode (>=1).
- SELW, derived, clog2(N_CH); not user-overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_bus  in  N_CH*WIDTH  packed channels; channel k = in_bus[k*WIDTH +: WIDTH].
- sel  in  SELW  manual channel select.
- en  in  1  block enable.
- scan  in  1  1 = auto-scan mode, 0 = manual.
- out  out  WIDTH  registered selected data.
- out_valid  out  1  out holds a legal channel's data.
- cur_ch  out  SELW  channel index driving out.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - out=0, out_valid=0, cur_ch=0.
  - Divider count=0, state=IDLE.
  - Release takes effect on the first clk edge with rst_n high.
- States IDLE, MANUAL, SCAN. Next state is computed each edge from en/scan:
  - en=0 -> IDLE.
  - en=1, scan=0 -> MANUAL.
  - en=1, scan=1 -> SCAN.
- IDLE:
  - out<=0, out_valid<=0.
  - cur_ch holds; divider cleared.
- MANUAL:
  - If sel<N_CH: out<=in_bus[sel], cur_ch<=sel, out_valid<=1. Latency is 1 clk from sel/in_bus to out.
  - If sel>=N_CH (N_CH not a power of 2): out<=0, out_valid<=0, cur_ch holds.
  - Divider held at 0.
- SCAN:
  - out<=in_bus[cur_ch], out_valid<=1 every cycle; sel is ignored.
  - Divider counts 0..SCAN_DIV-1. On the edge where count==SCAN_DIV-1, count<=0 and cur_ch advances by 1.
  - cur_ch wraps from N_CH-1 to 0.
  - out is registered from the pre-edge cur_ch, so each channel appears on out for exactly SCAN_DIV consecutive cycles. out lags cur_ch by 1 cycle at each transition.
  - SCAN_DIV=1: advance every cycle.
- Mode switches:
  - Entering SCAN from MANUAL/IDLE: scan starts at the current cur_ch, divider at 0.
  - Leaving SCAN: divider cleared; a later re-entry restarts the full SCAN_DIV dwell.
- Simultaneous en fall and terminal count: IDLE wins; cur_ch does not advance.
- Reset mid-scan: all state cleared immediately; scan restarts at channel 0.
- Widths: divider width clog2(SCAN_DIV) (min 1); cur_ch increment is modulo N_CH, not 2^SELW.

Optional Feature:
- Macro: SCAN_MUX_HOLD_ON_DISABLE_EN
- Defined: in IDLE, out and out_valid hold their last values instead of clearing. cur_ch holds. Reset still clears everything.
- Undefined: IDLE clears out/out_valid as above, matching the legacy enable-mux semantics (disabled output = 0).

Decomposition:
- Package scan_mux_pkg:
  - State enum (IDLE/MANUAL/SCAN).
  - clog2-based width helper function for SELW and divider width.
  - Default parameter constants.
- Sub-module scan_mux_div_counter:
  - Parametrised by SCAN_DIV.
  - Inputs: clk, rst_n, clr, inc_en. Output: tc pulse.
  - Instantiated once.
- Channel select and output register stay in the top.

Test Plan (N_CH=4, WIDTH=8, SCAN_DIV=3 unless stated):
1. Reset: rst_n=0 mid-run with en=1,scan=1 -> out=0x00, out_valid=0, cur_ch=0 immediately, before the next clk.
2. Manual: in_bus={0x44,0x33,0x22,0x11}, en=1, scan=0, sel=2 -> out=0x33, cur_ch=2, out_valid=1 one edge later; sel=0 -> out=0x11 next edge.
3. Scan rotation: same data, scan=1 from cur_ch=0 -> out sequence 0x11 x3, 0x22 x3, 0x33 x3, 0x44 x3, then 0x11 again (wrap).
4. Disable: en=0 during scan -> next edge out=0x00, out_valid=0, cur_ch frozen. With SCAN_MUX_HOLD_ON_DISABLE_EN defined, out keeps its last value and out_valid stays 1.
5. Out-of-range: N_CH=3, sel=3, scan=0 -> out=0, out_valid=0, cur_ch unchanged.
6. Mode switch: manual sel=1 then scan=1 -> 0x22 presented for 3 cycles, then 0x33. en drop on terminal-count cycle -> cur_ch stays 1.
